// File: rtl/noc_pkg.sv
// Shared router definitions: port-index width helper, port-index type and
// mesh direction constants.
package noc_pkg;

    // Width needed to index n ports; never narrower than one bit.
    function automatic int port_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int NUM_DIRS = 4;
    localparam int DIR_W    = port_w(NUM_DIRS);

    typedef logic [DIR_W-1:0] port_idx_t;

    localparam port_idx_t NORTH = 2'd0;
    localparam port_idx_t EAST  = 2'd1;
    localparam port_idx_t SOUTH = 2'd2;
    localparam port_idx_t WEST  = 2'd3;

endpackage

// File: rtl/xbar_sched_rr_pick.sv
// N-way rotating-priority picker: returns the first set request found when
// scanning from ptr upward with wrap-around.
module rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         found,
    output logic [W-1:0] idx
);

    int j;

    // Scan farthest-first so the closest request to ptr is written last.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        j     = 0;
        for (int k = N - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % N;
            if (req[j]) begin
                found = 1'b1;
                idx   = W'(j);
            end
        end
    end

endmodule

// File: rtl/xbar_sched.sv
// Crossbar scheduler for one mesh router: per-output round-robin matching of
// input FIFO heads to output FIFOs, with registered pop/push strobes.
module xbar_sched
    import noc_pkg::*;
#(
    parameter int  N_PORTS  = 4,
    parameter int  PCKG_SZ  = 40,
    parameter int  WAIT_MAX = 255,
    localparam int PORT_W   = port_w(N_PORTS),
    localparam int CNT_W    = $clog2(WAIT_MAX + 1)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              en,
    input  logic [N_PORTS-1:0]                pndng_i,
    input  logic [N_PORTS-1:0][PORT_W-1:0]    dest_i,
    input  logic [N_PORTS-1:0][PCKG_SZ-1:0]   data_in,
    input  logic [N_PORTS-1:0]                out_full,
    output logic [N_PORTS-1:0]                pop_i,
    output logic [N_PORTS-1:0]                push_o,
    output logic [N_PORTS-1:0][PCKG_SZ-1:0]   data_out,
    output logic [N_PORTS-1:0][PORT_W-1:0]    sel_o,
    output logic [N_PORTS-1:0]                starve,
    output logic                              dest_err
);

    logic [N_PORTS-1:0]               in_range;
    logic [N_PORTS-1:0]               req;
    logic [N_PORTS-1:0]               elig;
    logic [N_PORTS-1:0]               found;
    logic [N_PORTS-1:0]               granted;
    logic [N_PORTS-1:0][N_PORTS-1:0]  cand;
    logic [N_PORTS-1:0][PORT_W-1:0]   win;
    logic [N_PORTS-1:0][PORT_W-1:0]   ptr;
    logic [N_PORTS-1:0][CNT_W-1:0]    wait_cnt;

    // An input just popped is masked because its FIFO head has not advanced yet;
    // an output just pushed is held off for one cycle.
    always_comb begin
        in_range = '0;
        req      = '0;
        cand     = '0;
        elig     = ~out_full & ~push_o;
        for (int i = 0; i < N_PORTS; i++) begin
            in_range[i] = (int'(dest_i[i]) < N_PORTS);
            req[i]      = en & pndng_i[i] & ~pop_i[i] & in_range[i];
            for (int o = 0; o < N_PORTS; o++) begin
                cand[o][i] = req[i] & elig[o] & (int'(dest_i[i]) == o);
            end
        end
    end

    for (genvar o = 0; o < N_PORTS; o++) begin : g_pick
        rr_pick #(.N(N_PORTS), .W(PORT_W)) pick (
            .req   (cand[o]),
            .ptr   (ptr[o]),
            .found (found[o]),
            .idx   (win[o])
        );
    end

    always_comb begin
        granted = '0;
        for (int o = 0; o < N_PORTS; o++) begin
            for (int i = 0; i < N_PORTS; i++) begin
                if (found[o] && int'(win[o]) == i) granted[i] = 1'b1;
            end
        end
    end

    always_comb begin
        starve = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            starve[i] = (wait_cnt[i] == CNT_W'(WAIT_MAX));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pop_i    <= '0;
            push_o   <= '0;
            data_out <= '0;
            sel_o    <= '0;
            ptr      <= '0;
            wait_cnt <= '0;
            dest_err <= 1'b0;
        end else begin
            pop_i    <= granted;
            push_o   <= found;
            dest_err <= |(pndng_i & ~in_range);
            for (int o = 0; o < N_PORTS; o++) begin
                if (found[o]) begin
                    data_out[o] <= data_in[win[o]];
                    sel_o[o]    <= win[o];
                    ptr[o]      <= (int'(win[o]) == N_PORTS - 1) ? '0 : win[o] + PORT_W'(1);
                end
            end
            // Wait counters freeze while scheduling is disabled.
            if (en) begin
                for (int i = 0; i < N_PORTS; i++) begin
                    if (!pndng_i[i] || granted[i]) begin
                        wait_cnt[i] <= '0;
                    end else if (req[i] && wait_cnt[i] != CNT_W'(WAIT_MAX)) begin
                        wait_cnt[i] <= wait_cnt[i] + CNT_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_xbar_sched.sv
// Scoreboard bench for xbar_sched: a distance-based round-robin model predicts
// each cycle's strobes, a separate monitor compares them against the DUT.
module tb_xbar_sched;

    localparam int N  = 4;
    localparam int WM = 255;

    typedef struct {
        logic [3:0]        pop;
        logic [3:0]        push;
        logic [3:0]        starve;
        logic              derr;
        logic [3:0][39:0]  data;
        logic [3:0][1:0]   sel;
    } exp_t;

    logic             clk, rst, en;
    logic [3:0]       pndng, out_full, pop, push, starve;
    logic [3:0][1:0]  dest, sel;
    logic [3:0][39:0] din, dout;
    logic             derr;

    logic [2:0]       pndng3, full3, pop3, push3, starve3;
    logic [2:0][1:0]  dest3, sel3;
    logic [2:0][39:0] din3, dout3;
    logic             derr3;

    int tests = 0;
    int fails = 0;

    exp_t             sb_q[$];
    int               m_ptr[4];
    int               m_cnt[4];
    logic [3:0]       m_pop, m_push;
    logic [3:0][39:0] m_data;
    logic [3:0][1:0]  m_sel;

    xbar_sched #(.N_PORTS(4), .PCKG_SZ(40), .WAIT_MAX(255)) dut (
        .clk(clk), .rst(rst), .en(en), .pndng_i(pndng), .dest_i(dest),
        .data_in(din), .out_full(out_full), .pop_i(pop), .push_o(push),
        .data_out(dout), .sel_o(sel), .starve(starve), .dest_err(derr)
    );

    xbar_sched #(.N_PORTS(3), .PCKG_SZ(40), .WAIT_MAX(255)) dut3 (
        .clk(clk), .rst(rst), .en(en), .pndng_i(pndng3), .dest_i(dest3),
        .data_in(din3), .out_full(full3), .pop_i(pop3), .push_o(push3),
        .data_out(dout3), .sel_o(sel3), .starve(starve3), .dest_err(derr3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Each output picks the requesting input closest (cyclically) after its pointer.
    task automatic model_step();
        exp_t       e;
        logic [3:0] req, gnt;
        int         best, bestd, d;
        if (rst) begin
            m_ptr  = '{default: 0};
            m_cnt  = '{default: 0};
            m_pop  = '0;
            m_push = '0;
            m_data = '0;
            m_sel  = '0;
            sb_q.delete();
            return;
        end
        req    = '0;
        gnt    = '0;
        e.push = '0;
        for (int i = 0; i < N; i++)
            req[i] = en && pndng[i] && !m_pop[i] && (int'(dest[i]) < N);
        for (int o = 0; o < N; o++) begin
            best  = -1;
            bestd = N;
            if (!out_full[o] && !m_push[o]) begin
                for (int i = 0; i < N; i++) begin
                    d = (i - m_ptr[o] + N) % N;
                    if (req[i] && int'(dest[i]) == o && d < bestd) begin
                        best  = i;
                        bestd = d;
                    end
                end
            end
            if (best >= 0) begin
                e.push[o] = 1'b1;
                gnt[best] = 1'b1;
                m_data[o] = din[best];
                m_sel[o]  = 2'(best);
                m_ptr[o]  = (best + 1) % N;
            end
        end
        if (en) begin
            for (int i = 0; i < N; i++) begin
                if (!pndng[i] || gnt[i]) m_cnt[i] = 0;
                else if (req[i] && m_cnt[i] < WM) m_cnt[i]++;
            end
        end
        m_pop  = gnt;
        m_push = e.push;
        e.pop  = gnt;
        e.data = m_data;
        e.sel  = m_sel;
        e.derr = 1'b0;
        for (int i = 0; i < N; i++) begin
            e.starve[i] = (m_cnt[i] == WM);
            if (pndng[i] && int'(dest[i]) >= N) e.derr = 1'b1;
        end
        sb_q.push_back(e);
    endtask

    task automatic monitor_step();
        exp_t e;
        if (rst || sb_q.size() == 0) return;
        e = sb_q.pop_front();
        check_val("pop_i", 64'(pop), 64'(e.pop));
        check_val("push_o", 64'(push), 64'(e.push));
        check_val("starve", 64'(starve), 64'(e.starve));
        check_val("dest_err", 64'(derr), 64'(e.derr));
        for (int o = 0; o < N; o++) begin
            check_val($sformatf("data_out[%0d]", o), 64'(dout[o]), 64'(e.data[o]));
            check_val($sformatf("sel_o[%0d]", o), 64'(sel[o]), 64'(e.sel[o]));
        end
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        monitor_step();
    end

    task automatic rand_data();
        for (int i = 0; i < N; i++) din[i] = {8'($urandom), $urandom};
    endtask

    task automatic idle(input int n);
        pndng = '0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int seq[3];
        seq = '{0, 1, 3};
        rst = 1'b1; en = 1'b0; pndng = '0; dest = '0; din = '0; out_full = '0;
        pndng3 = '0; dest3 = '0; din3 = '0; full3 = '0;
        repeat (3) @(negedge clk);
        check_val("reset_pop", 64'(pop), 64'd0);
        check_val("reset_push", 64'(push), 64'd0);
        check_val("reset_starve", 64'(starve), 64'd0);
        check_val("reset_dest_err", 64'(derr), 64'd0);
        rst = 1'b0;
        en  = 1'b1;

        // Single transfer 0 -> 2.
        pndng = 4'b0001; dest[0] = 2'd2; din[0] = 40'hAA;
        @(negedge clk);
        check_val("t1_pop", 64'(pop), 64'h1);
        check_val("t1_push", 64'(push), 64'h4);
        check_val("t1_data", 64'(dout[2]), 64'hAA);
        check_val("t1_sel", 64'(sel[2]), 64'd0);
        idle(2);

        // Inputs 0, 1, 3 contend for output 1.
        pndng = 4'b1011;
        for (int i = 0; i < N; i++) dest[i] = 2'd1;
        for (int k = 0; k < 12; k++) begin
            rand_data();
            @(negedge clk);
            if (k % 2 == 0) begin
                check_val("t2_push_on", 64'(push[1]), 64'd1);
                check_val("t2_winner", 64'(sel[1]), 64'(seq[(k / 2) % 3]));
            end else begin
                check_val("t2_push_off", 64'(push[1]), 64'd0);
            end
        end
        idle(2);

        // Full permutation in one cycle.
        pndng = 4'b1111;
        dest[0] = 2'd3; dest[1] = 2'd2; dest[2] = 2'd1; dest[3] = 2'd0;
        rand_data();
        @(negedge clk);
        check_val("t3_pop", 64'(pop), 64'hF);
        check_val("t3_push", 64'(push), 64'hF);
        for (int o = 0; o < N; o++) check_val("t3_sel", 64'(sel[o]), 64'(3 - o));
        idle(2);

        // Backpressure until starvation, then release.
        out_full = 4'b0100; pndng = 4'b0001; dest[0] = 2'd2;
        repeat (300) @(negedge clk);
        check_val("t4_starve_set", 64'(starve[0]), 64'd1);
        check_val("t4_no_push", 64'(push[2]), 64'd0);
        out_full = '0;
        @(negedge clk);
        check_val("t4_push_release", 64'(push[2]), 64'd1);
        check_val("t4_pop_release", 64'(pop[0]), 64'd1);
        check_val("t4_starve_clr", 64'(starve[0]), 64'd0);
        idle(2);

        // Enable low, then reset during a grant.
        en = 1'b0; pndng = 4'b1111; dest = 8'($urandom);
        repeat (4) begin
            @(negedge clk);
            check_val("t5_en_pop", 64'(pop), 64'd0);
            check_val("t5_en_push", 64'(push), 64'd0);
        end
        en = 1'b1; pndng = 4'b1010; dest[1] = 2'd0; dest[3] = 2'd0;
        @(negedge clk);
        check_val("t5_pre_push", 64'(push[0]), 64'd1);
        check_val("t5_pre_sel", 64'(sel[0]), 64'd1);
        #1 rst = 1'b1;
        #1;
        check_val("t5_rst_pop", 64'(pop), 64'd0);
        check_val("t5_rst_push", 64'(push), 64'd0);
        check_val("t5_rst_data", 64'(dout[0]), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_val("t5_post_push", 64'(push[0]), 64'd1);
        check_val("t5_post_sel", 64'(sel[0]), 64'd1);
        idle(2);

        // Randomized traffic.
        for (int k = 0; k < 1500; k++) begin
            en       = ($urandom % 8) != 0;
            pndng    = 4'($urandom);
            dest     = 8'($urandom);
            out_full = 4'($urandom) & 4'($urandom);
            rand_data();
            @(negedge clk);
        end
        en = 1'b1; out_full = '0;
        idle(2);

        // Out-of-range destination on the 3-port instance.
        pndng3 = 3'b011; dest3[0] = 2'd2; dest3[1] = 2'd3; dest3[2] = 2'd0;
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < 3; i++) din3[i] = {8'($urandom), $urandom};
            @(negedge clk);
            check_val("t6_dest_err", 64'(derr3), 64'd1);
            check_val("t6_no_pop1", 64'(pop3[1]), 64'd0);
            check_val("t6_pop0", 64'(pop3[0]), 64'(k % 2 == 0));
            check_val("t6_push2", 64'(push3[2]), 64'(k % 2 == 0));
        end
        pndng3 = '0;
        @(negedge clk);
        check_val("t6_dest_err_clr", 64'(derr3), 64'd0);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
